// File: rtl/hex_display_pkg.sv
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared seven-segment types and active-low glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low gfedcba glyphs; b and d are lower case to stay distinct from 8 and 0.
    localparam seg7_t HEX_SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/hex_seg_decode.sv
// ============================================================================
// Module      : hex_seg_decode
// Description : Combinational nibble + blank to active-low seven-segment code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'h0:    seg = HEX_SEG_LUT[0];
                4'h1:    seg = HEX_SEG_LUT[1];
                4'h2:    seg = HEX_SEG_LUT[2];
                4'h3:    seg = HEX_SEG_LUT[3];
                4'h4:    seg = HEX_SEG_LUT[4];
                4'h5:    seg = HEX_SEG_LUT[5];
                4'h6:    seg = HEX_SEG_LUT[6];
                4'h7:    seg = HEX_SEG_LUT[7];
                4'h8:    seg = HEX_SEG_LUT[8];
                4'h9:    seg = HEX_SEG_LUT[9];
                4'hA:    seg = HEX_SEG_LUT[10];
                4'hB:    seg = HEX_SEG_LUT[11];
                4'hC:    seg = HEX_SEG_LUT[12];
                4'hD:    seg = HEX_SEG_LUT[13];
                4'hE:    seg = HEX_SEG_LUT[14];
                4'hF:    seg = HEX_SEG_LUT[15];
                // Unknown nibbles in simulation fall back to a dark digit.
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hex_display.sv
// ============================================================================
// Module      : hex_display
// Description : One HEX digit driver: decode, polarity select, output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display
    import hex_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank,
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // All-off level follows the board polarity so reset always darkens the digit.
    localparam seg7_t c_seg_off = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    seg7_t w_pattern;
    seg7_t w_drive;

    hex_seg_decode u_decode (
        .digit (digit),
        .blank (blank),
        .seg   (w_pattern)
    );

    assign w_drive = ACTIVE_LOW ? w_pattern : ~w_pattern;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= c_seg_off;
        end else if (en) begin
            seg <= w_drive;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hex_display.sv
// ============================================================================
// Module      : tb_hex_display
// Description : Scoreboard bench for hex_display in both segment polarities.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display;

    typedef struct {
        int         due;
        bit         ah;
        logic [6:0] exp;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       blank = 1'b0;
    logic [3:0] digit = 4'h8;
    logic [6:0] seg;
    logic [6:0] seg_ah;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    event chk_ev;

    hex_display #(.ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .blank (blank),
        .digit (digit),
        .seg   (seg)
    );

    hex_display #(.ACTIVE_LOW(1'b0)) dut_ah (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .blank (blank),
        .digit (digit),
        .seg   (seg_ah)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that has come due.
    always begin
        @(negedge clk or chk_ev);
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t       e;
            logic [6:0] act;
            e   = q.pop_front();
            act = e.ah ? seg_ah : seg;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s%s: got %02h expected %02h", e.name,
                         e.ah ? "_active_high" : "", act, e.exp);
            end
        end
    end

    // Active-high copy is the bitwise complement of the active-low expectation.
    task automatic push_exp(input int due, input logic [6:0] ex, input string nm);
        exp_t a;
        exp_t b;
        a = '{due: due, ah: 1'b0, exp: ex,  name: nm};
        b = '{due: due, ah: 1'b1, exp: ~ex, name: nm};
        q.push_back(a);
        q.push_back(b);
    endtask

    task automatic load(input logic e, input logic b, input logic [3:0] d,
                        input logic [6:0] ex, input string nm);
        @(posedge clk);
        #1;
        en    = e;
        blank = b;
        digit = d;
        push_exp(cyc + 1, ex, nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    logic [6:0] sweep_exp [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    initial begin
        // Async reset check lands before the first rising edge at t=5.
        #1 reset = 1'b1;
        #1 push_exp(cyc, 7'h7F, "reset_async");
        -> chk_ev;
        checks++;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL reset_direct: got %02h expected 7f", seg);
        end
        checks++;
        if (seg_ah !== 7'h00) begin
            errors++;
            $display("FAIL reset_direct_active_high: got %02h expected 00", seg_ah);
        end
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            load(1'b1, 1'b0, 4'(i), sweep_exp[i], $sformatf("sweep_%0h", i));
        end

        load(1'b1, 1'b0, 4'h5, 7'h12, "hold_load");
        for (int i = 0; i < 10; i++) begin
            load(1'b0, 1'b0, 4'hE, 7'h12, $sformatf("hold_%0d", i));
        end

        load(1'b1, 1'b1, 4'h3, 7'h7F, "blank_on");
        load(1'b1, 1'b0, 4'h3, 7'h30, "blank_off");

        load(1'b1, 1'b0, 4'hA, 7'h08, "pre_reset_a");
        drain();

        @(negedge clk);
        en = 1'b0;
        #2 reset = 1'b1;
        #1 push_exp(cyc, 7'h7F, "mid_reset_async");
        -> chk_ev;
        checks++;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL mid_reset_direct: got %02h expected 7f", seg);
        end
        checks++;
        if (seg_ah !== 7'h00) begin
            errors++;
            $display("FAIL mid_reset_direct_active_high: got %02h expected 00", seg_ah);
        end
        #1 reset = 1'b0;
        load(1'b0, 1'b0, 4'h1, 7'h7F, "post_reset_hold");
        load(1'b1, 1'b0, 4'h1, 7'h79, "post_reset_load");
        load(1'b0, 1'b0, 4'h1, 7'h79, "final_hold");

        drain();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            errors++;
            $display("FAIL %s: got no sample expected %02h (timeout)", e.name, e.exp);
        end

        checks++;
        if (seg !== 7'h79) begin
            errors++;
            $display("FAIL final_direct: got %02h expected 79", seg);
        end
        checks++;
        if (seg_ah !== 7'h06) begin
            errors++;
            $display("FAIL final_direct_active_high: got %02h expected 06", seg_ah);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
